// File: rtl/alu_if.sv
// Operand/result bundle between the host harness and the ALU core.
interface alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             overflow;

  // Host side: issues operations, observes results.
  modport master (
    output in_valid, opcode, A, B,
    input  result, out_valid, carry, zero, negative, overflow
  );

  // ALU side.
  modport slave (
    input  in_valid, opcode, A, B,
    output result, out_valid, carry, zero, negative, overflow
  );
endinterface

// File: rtl/alu.sv
// 8-bit registered ALU: 16 ops, one-cycle latency, flags held between ops.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_NOT  = 4'd5,  OP_NAND = 4'd6,  OP_NOR  = 4'd7,
    OP_XNOR = 4'd8,  OP_SHL  = 4'd9,  OP_SHR  = 4'd10, OP_SAR  = 4'd11,
    OP_ROL  = 4'd12, OP_ROR  = 4'd13, OP_MUL  = 4'd14, OP_LTU  = 4'd15
  } op_e;

  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               negative_q, negative_d;
  logic               overflow_q, overflow_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_v;

  logic [WIDTH:0]     sum_w, diff_w, shl_w, shr_w, sar_w;
  logic [2*WIDTH-1:0] prod_w, rol_w, ror_w;
  logic [2:0]         sh;

  // Datapath candidates; shifters carry one extra bit to capture the shift-out.
  always_comb begin
    sh     = bus.B[2:0];
    sum_w  = {1'b0, bus.A} + {1'b0, bus.B};
    diff_w = {1'b0, bus.A} - {1'b0, bus.B};
    prod_w = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    shl_w  = {1'b0, bus.A} << sh;
    shr_w  = {bus.A, 1'b0} >> sh;
    sar_w  = $signed({bus.A, 1'b0}) >>> sh;
    rol_w  = {bus.A, bus.A} << sh;
    ror_w  = {bus.A, bus.A} >> sh;
  end

  // Opcode select: result, carry and signed overflow for the incoming op.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_e'(bus.opcode))
      OP_ADD: begin
        alu_r = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];
        alu_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (alu_r[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = diff_w[WIDTH-1:0];
        alu_c = diff_w[WIDTH];
        alu_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (alu_r[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  alu_r = bus.A & bus.B;
      OP_OR:   alu_r = bus.A | bus.B;
      OP_XOR:  alu_r = bus.A ^ bus.B;
      OP_NOT:  alu_r = ~bus.A;
      OP_NAND: alu_r = ~(bus.A & bus.B);
      OP_NOR:  alu_r = ~(bus.A | bus.B);
      OP_XNOR: alu_r = ~(bus.A ^ bus.B);
      // Shift-out bit is zero naturally when the amount is zero.
      OP_SHL: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_r = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      OP_SAR: begin
        alu_r = sar_w[WIDTH:1];
        alu_c = sar_w[0];
      end
      OP_ROL:  alu_r = rol_w[2*WIDTH-1:WIDTH];
      OP_ROR:  alu_r = ror_w[WIDTH-1:0];
      OP_MUL: begin
        alu_r = prod_w[WIDTH-1:0];
        alu_c = |prod_w[2*WIDTH-1:WIDTH];
      end
      OP_LTU:  alu_r = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      default: ;
    endcase
  end

  // Next state: capture on in_valid, otherwise hold everything but out_valid.
  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      result_d    = alu_r;
      carry_d     = alu_c;
      zero_d      = (alu_r == '0);
      negative_d  = alu_r[WIDTH-1];
      overflow_d  = alu_v;
      out_valid_d = 1'b1;
    end
  end

  // Output registers; reset wins over a concurrent or in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected outputs queued at issue, popped at output.
module tb_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_if #(.WIDTH(8)) bus ();
  alu #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       negative;
    logic       overflow;
    logic       out_valid;
  } outs_t;

  // One table row: op, A, B, expected result and carry from the test plan.
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
  } vec_t;

  outs_t q[$];
  outs_t last;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model written bit-serially, independent of the RTL datapath.
  function automatic outs_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    outs_t o;
    int    ia, ib, sa, sb, t;
    logic [7:0] r;
    logic c, v;
    ia = int'(a); ib = int'(b);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    r = a; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin t = ia + ib; r = t[7:0]; c = (t > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin t = ia - ib; r = t[7:0]; c = (ia < ib);  v = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = ~(a & b);
      4'd7: r = ~(a | b);
      4'd8: r = ~(a ^ b);
      4'd9:  for (int i = 0; i < int'(b[2:0]); i++) begin c = r[7]; r = {r[6:0], 1'b0}; end
      4'd10: for (int i = 0; i < int'(b[2:0]); i++) begin c = r[0]; r = {1'b0, r[7:1]}; end
      4'd11: for (int i = 0; i < int'(b[2:0]); i++) begin c = r[0]; r = {r[7], r[7:1]}; end
      4'd12: for (int i = 0; i < int'(b[2:0]); i++) r = {r[6:0], r[7]};
      4'd13: for (int i = 0; i < int'(b[2:0]); i++) r = {r[0], r[7:1]};
      4'd14: begin t = ia * ib; r = t[7:0]; c = (t > 255); end
      default: r = (ia < ib) ? 8'd1 : 8'd0;
    endcase
    o.result = r; o.carry = c; o.zero = (r == 8'd0); o.negative = r[7];
    o.overflow = v; o.out_valid = 1'b1;
    return o;
  endfunction

  function automatic outs_t obs();
    outs_t o;
    o.result = bus.result; o.carry = bus.carry; o.zero = bus.zero;
    o.negative = bus.negative; o.overflow = bus.overflow; o.out_valid = bus.out_valid;
    return o;
  endfunction

  // Drive one op on the falling edge and push its expected outputs.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = op; bus.A = a; bus.B = b;
    q.push_back(model(op, a, b));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    outs_t got;
    bus.in_valid = 1'b0; bus.opcode = 4'd0; bus.A = 8'd0; bus.B = 8'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    got = obs();
    n_cmp++;
    if (got !== 13'd0) begin
      n_bad++; $display("FAIL reset got=%h required=%h", got, 13'd0);
    end
    last = got;
  endtask

  // Runs a plan table back-to-back: model check plus plan-constant check.
  task automatic test_table(input string name, input vec_t tbl[]);
    outs_t got, exp;
    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b);
      @(posedge clk); #1;
      got = obs();
      exp = q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s[%0d] op=%0d A=%h B=%h got=%h required=%h", name, i, tbl[i].op, tbl[i].a, tbl[i].b, got, exp);
      end
      n_cmp++;
      if ({got.result, got.carry} !== {tbl[i].res, tbl[i].c}) begin
        n_bad++;
        $display("FAIL %s_plan[%0d] got res=%h c=%b required res=%h c=%b", name, i, got.result, got.carry, tbl[i].res, tbl[i].c);
      end
      last = got;
    end
    idle();
  endtask

  task automatic test_add_sub();
    vec_t t[] = '{'{4'd0, 8'd200, 8'd100, 8'd44, 1'b1}, '{4'd0, 8'd100, 8'd100, 8'd200, 1'b0},
                  '{4'd1, 8'd5, 8'd5, 8'd0, 1'b0},      '{4'd1, 8'd3, 8'd10, 8'd249, 1'b1}};
    test_table("addsub", t);
  endtask

  task automatic test_logic();
    vec_t t[] = '{'{4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0}, '{4'd3, 8'hF0, 8'h3C, 8'hFC, 1'b0},
                  '{4'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0}, '{4'd5, 8'hF0, 8'h3C, 8'h0F, 1'b0},
                  '{4'd6, 8'hF0, 8'h3C, 8'hCF, 1'b0}, '{4'd7, 8'hF0, 8'h3C, 8'h03, 1'b0},
                  '{4'd8, 8'hF0, 8'h3C, 8'h33, 1'b0}};
    test_table("logic", t);
  endtask

  task automatic test_shift();
    vec_t t[] = '{'{4'd9,  8'h81, 8'd1, 8'h02, 1'b1}, '{4'd10, 8'h81, 8'd1, 8'h40, 1'b1},
                  '{4'd11, 8'h81, 8'd1, 8'hC0, 1'b1}, '{4'd12, 8'h81, 8'd1, 8'h03, 1'b0},
                  '{4'd13, 8'h81, 8'd1, 8'hC0, 1'b0}, '{4'd9,  8'h81, 8'd9, 8'h02, 1'b1},
                  '{4'd9,  8'h81, 8'd0, 8'h81, 1'b0}, '{4'd10, 8'hB6, 8'd3, 8'h16, 1'b1},
                  '{4'd11, 8'hB6, 8'd2, 8'hED, 1'b1}, '{4'd12, 8'hB6, 8'd3, 8'hB5, 1'b0}};
    test_table("shift", t);
  endtask

  // MUL then LTU with in_valid held high, then three idle cycles of hold.
  task automatic test_back_to_back();
    vec_t t[] = '{'{4'd14, 8'd20, 8'd20, 8'd144, 1'b1}, '{4'd15, 8'd3, 8'd7, 8'd1, 1'b0}};
    outs_t got, exp;
    test_table("b2b", t);
    exp = last; exp.out_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = obs();
      n_cmp++;
      if (got !== exp || got.result !== 8'd1) begin
        n_bad++; $display("FAIL hold[%0d] got=%h required=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_random();
    outs_t got, exp;
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
      got = obs();
      exp = q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL random[%0d] got=%h required=%h", i, got, exp);
      end
    end
    idle();
  endtask

  // Op accepted, then reset asserted with in_valid still high on the next edge.
  task automatic test_reset_inflight();
    outs_t got;
    send(4'd0, 8'd200, 8'd100);
    @(negedge clk);
    rst = 1'b1; bus.opcode = 4'd5; bus.A = 8'h00;
    @(posedge clk); #1;
    q.delete();
    got = obs();
    n_cmp++;
    if (got !== 13'd0) begin
      n_bad++; $display("FAIL reset_inflight got=%h required=%h", got, 13'd0);
    end
    @(negedge clk); rst = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_shift();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
